// File: rtl/expr_tx_if.sv
// Handshake bundle between the expression source, expr_tx and its character sink.
// The master side is the transmitter: it takes the request and drives the character stream.
interface expr_tx_if #(
  parameter int MAX_TERMS = 8
);
  localparam int OPS_W = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1;

  logic                   start;
  logic [3:0]             num_terms;
  logic [4*MAX_TERMS-1:0] digits;
  logic [OPS_W-1:0]       ops;
  logic                   out_ready;
  logic [7:0]             out_char;
  logic                   out_valid;
  logic                   out_last;
  logic                   busy;
  logic                   err;

  modport master (
    input  start, num_terms, digits, ops, out_ready,
    output out_char, out_valid, out_last, busy, err
  );

  modport slave (
    output start, num_terms, digits, ops, out_ready,
    input  out_char, out_valid, out_last, busy, err
  );
endinterface

// File: rtl/expr_tx.sv
// Serializes a packed arithmetic expression (BCD operands, +/* operators) into an
// ASCII character stream with a valid/ready handshake.

// One operand's share of request validation: a digit only matters if it is in use.
module expr_tx_term #(
  parameter int IDX = 0
) (
  input  logic [3:0] num_terms,
  input  logic [3:0] digit,
  output logic       ok
);
  assign ok = (num_terms <= 4'(IDX)) || (digit <= 4'd9);
endmodule

module expr_tx #(
  parameter int MAX_TERMS = 8
) (
  input  logic        clk,
  input  logic        clr,
  expr_tx_if.master   bus
);
  localparam int OPS_W = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1;

  typedef enum logic [1:0] {IDLE, DIGIT, OP} state_t;

  state_t                      state, state_d;
  logic [3:0]                  idx, idx_d;
  logic [3:0]                  cnt, cnt_d;
  logic [MAX_TERMS-1:0][3:0]   dig_q, dig_d;
  logic [OPS_W-1:0]            ops_q, ops_d;
  logic                        err_q, err_d;

  logic [MAX_TERMS-1:0]        term_ok;
  logic                        req_ok;
  logic [3:0]                  cur_dig;
  logic                        cur_op;
  logic                        is_last;

  generate
    for (genvar i = 0; i < MAX_TERMS; i++) begin : gen_term
      expr_tx_term #(.IDX(i)) u_term (
        .num_terms (bus.num_terms),
        .digit     (bus.digits[4*i +: 4]),
        .ok        (term_ok[i])
      );
    end
  endgenerate

  assign req_ok = (bus.num_terms != 4'd0) && (bus.num_terms <= 4'(MAX_TERMS)) && (&term_ok);

  // Operand/operator at the current index, selected from the captured copy only.
  always_comb begin
    cur_dig = 4'd0;
    for (int i = 0; i < MAX_TERMS; i++)
      if (idx == 4'(i)) cur_dig = dig_q[i];
  end

  always_comb begin
    cur_op = 1'b0;
    for (int i = 0; i < OPS_W; i++)
      if (idx == 4'(i)) cur_op = ops_q[i];
  end

  assign is_last = (idx == cnt - 4'd1);

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      idx   <= 4'd0;
      cnt   <= 4'd0;
      dig_q <= '0;
      ops_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      dig_q <= dig_d;
      ops_q <= ops_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    dig_d   = dig_q;
    ops_d   = ops_q;
    err_d   = err_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          cnt_d   = bus.num_terms;
          dig_d   = bus.digits;
          ops_d   = bus.ops;
          idx_d   = 4'd0;
          err_d   = ~req_ok;
          state_d = req_ok ? DIGIT : IDLE;
        end
      end
      DIGIT: begin
        if (bus.out_ready) state_d = is_last ? IDLE : OP;
      end
      OP: begin
        if (bus.out_ready) begin
          idx_d   = idx + 4'd1;
          state_d = DIGIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; out_ready/start never reach them combinationally.
  always_comb begin
    bus.out_valid = (state != IDLE);
    bus.busy      = (state != IDLE);
    bus.err       = err_q;
    bus.out_last  = (state == DIGIT) && is_last;
    bus.out_char  = 8'd0;
    case (state)
      DIGIT:   bus.out_char = {4'b0, cur_dig} + 8'd48;
      OP:      bus.out_char = cur_op ? 8'd42 : 8'd43;
      default: bus.out_char = 8'd0;
    endcase
  end
endmodule

// File: tb/tb_expr_tx.sv
// Directed and randomized bench for expr_tx; expected streams come from a queue model
// built straight from the expression text rules.
module tb_expr_tx;
  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  expr_tx_if #(.MAX_TERMS(8)) bus ();
  expr_tx #(.MAX_TERMS(8)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input int n, input logic [31:0] d);
    if (n < 1 || n > 8) return 1'b1;
    for (int i = 0; i < n; i++)
      if (d[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // rmode: 0 ready always, 1 pattern 1,0,0,1,0,1..., 2 random. poke: restart while busy.
  task automatic run_expr(input int n, input logic [31:0] d, input logic [6:0] o,
                          input int rmode, input bit poke);
    logic [7:0] q[$];
    bit         e;
    int         sz, got, cyc;
    logic       pv, pr, pl;
    logic [7:0] pc;
    e = model_err(n, d);
    if (!e)
      for (int i = 0; i < n; i++) begin
        q.push_back(8'(48 + int'(d[4*i +: 4])));
        if (i < n - 1) q.push_back(o[i] ? 8'd42 : 8'd43);
      end
    sz = q.size();
    bus.num_terms = 4'(n);
    bus.digits    = d;
    bus.ops       = o;
    bus.start     = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.num_terms = 4'($urandom);
    bus.digits    = $urandom;
    bus.ops       = 7'($urandom);
    chk("err", bus.err, e);
    if (e) begin
      repeat (3) begin
        chk("rej_valid", bus.out_valid, 0);
        chk("rej_busy", bus.busy, 0);
        chk("err_sticky", bus.err, 1);
        @(negedge clk);
      end
      return;
    end
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_busy", bus.busy, 1);
    got = 0; cyc = 0; pv = 1'b0; pr = 1'b1; pl = 1'b0; pc = 8'd0;
    while (got < sz && cyc < 300) begin
      if (pv && !pr) begin
        chk("hold_char", bus.out_char, pc);
        chk("hold_last", bus.out_last, pl);
        chk("hold_valid", bus.out_valid, 1);
      end
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ((cyc % 6) == 0) || ((cyc % 6) == 3) || ((cyc % 6) == 5);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && cyc == 1) begin
        bus.start = 1'b1; bus.num_terms = 4'd2; bus.digits = 32'h55; bus.ops = 7'd1;
      end else bus.start = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        chk("char", bus.out_char, q[got]);
        chk("last", bus.out_last, (got == sz - 1));
        got++;
      end
      pv = bus.out_valid; pr = bus.out_ready; pc = bus.out_char; pl = bus.out_last;
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("count", got, sz);
    chk("end_valid", bus.out_valid, 0);
    chk("end_last", bus.out_last, 0);
    chk("end_busy", bus.busy, 0);
    if (poke)
      repeat (4) begin
        @(negedge clk);
        chk("no_second", bus.out_valid, 0);
      end
  endtask

  initial begin
    logic [31:0] d;
    clr = 1'b1;
    bus.start = 1'b0; bus.num_terms = 4'd0; bus.digits = '0; bus.ops = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    // start during reset must be overridden
    bus.start = 1'b1; bus.num_terms = 4'd3; bus.digits = 32'h832; bus.ops = 7'b01;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst_char", bus.out_char, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    clr = 1'b0;
    @(negedge clk);

    run_expr(3, 32'h832, 7'b01, 0, 1'b0);
    run_expr(3, 32'h832, 7'b01, 1, 1'b0);
    run_expr(1, 32'h7, 7'b0, 0, 1'b0);
    run_expr(2, 32'hA4, 7'b0, 0, 1'b0);
    run_expr(2, 32'h91, 7'b0, 0, 1'b0);

    // abort after two transfers
    bus.num_terms = 4'd3; bus.digits = 32'h832; bus.ops = 7'b01; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_abort_char", bus.out_char, 51);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_char", bus.out_char, 0);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_last", bus.out_last, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_err", bus.err, 0);
    @(negedge clk);
    chk("abort_quiet", bus.out_valid, 0);
    run_expr(2, 32'h91, 7'b0, 0, 1'b0);

    run_expr(3, 32'h832, 7'b01, 0, 1'b1);
    run_expr(0, 32'h1, 7'b0, 0, 1'b0);
    run_expr(9, 32'h1, 7'b0, 0, 1'b0);
    run_expr(8, 32'h99999999, 7'h55, 2, 1'b0);
    run_expr(2, 32'hFFFFFF12, 7'h7F, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      int n;
      n = $urandom_range(1, 8);
      d = '0;
      for (int i = 0; i < 8; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) d[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
      run_expr(n, d, 7'($urandom), 2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/expr_tx.md
# expr_tx

Serializing transmitter for the arithmetic-expression character stream consumed by the `string` recognizer. It accepts a packed expression description (operand digits plus operator selects) on a start pulse. It then emits the expression as 8-bit ASCII characters, one per accepted handshake: digit, operator, digit, and so on. It sits upstream of the recognizer's `in` port and serves as its stimulus and traffic source.

## Interface
- `MAX_TERMS`, default 8: maximum operand count; legal range 1..15.
- `clk` in 1: single clock; all state changes on its rising edge.
- `clr` in 1: synchronous, active-high reset.
- `start` in 1: request to transmit a new expression; sampled only in IDLE.
- `num_terms` in 4: number of operands, legal range 1..`MAX_TERMS`.
- `digits` in 4*`MAX_TERMS`: BCD operand i at [4i+3:4i]; operand 0 is sent first.
- `ops` in `MAX_TERMS`-1: bit i is the operator between operand i and operand i+1; 0 = '+' (43), 1 = '*' (42).
- `out_ready` in 1: sink can accept a character this cycle.
- `out_char` out 8: ASCII character.
- `out_valid` out 1: `out_char` is valid.
- `out_last` out 1: high together with `out_valid` on the final character.
- `busy` out 1: an expression is in flight (not IDLE).
- `err` out 1: the last start request was rejected.

## Operation
- States: IDLE, DIGIT, OP.
- Handshake: a character transfers on a rising edge where `out_valid` & `out_ready` are both 1.
- IDLE, `start`=1:
  - Capture `num_terms`, `digits` and `ops` into internal registers; inputs may change afterwards.
  - Clear the term index to 0.
  - Validate the request.
- Validation fails if `num_terms`==0, or `num_terms`>`MAX_TERMS`, or any of the first `num_terms` digits is >9.
  - On failure: set `err`=1, stay in IDLE, emit nothing.
  - On success: set `err`=0 and go to DIGIT.
- DIGIT: `out_valid`=1, `out_char`=48+digit[idx], `out_last`=(idx==count-1).
  - On handshake with `out_last`=1: go to IDLE.
  - On handshake otherwise: go to OP.
- OP: `out_valid`=1, `out_char`=ops[idx] ? 42 : 43, `out_last`=0.
  - On handshake: idx←idx+1, go to DIGIT.
- An expression of n operands produces exactly 2n−1 characters.
- `start` is ignored while `busy`=1; captured data and idx are untouched.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_char`, `out_last` and state hold unchanged.
- `out_ready` is ignored while `out_valid`=0.
- `err` is sticky. It changes only on an accepted `start`, where it takes the validation result, or on `clr`.
- Digit-to-ASCII conversion is 8-bit: {4'b0, digit} + 8'd48. No overflow is possible for a digit ≤9.

## Timing
- Reset (`clr`=1 at an edge) forces, after that edge:
  - state IDLE, idx 0;
  - `out_char`=0, `out_valid`=0, `out_last`=0, `busy`=0, `err`=0.
- `clr` overrides `start` and any handshake in the same cycle.
- `clr` mid-stream aborts the expression; no further characters are emitted.
- Start latency: `start` sampled at edge k → `out_valid`=1 and `busy`=1 from edge k onward, so the first character is visible in the cycle after the `start` cycle.
- Throughput: one character per cycle while `out_ready` is held at 1, with no bubbles between digit and operator.
- End of expression: after the handshake edge of the last character, `out_valid`=0, `out_last`=0 and `busy`=0. A new `start` is accepted in that very next cycle.
- All outputs are registered or decoded from registered state only. No combinational path from `out_ready` or `start` to any output.

## Test plan
- `clr` held, then `num_terms`=3, `digits`={8,3,2} (operand0=2), `ops`=2'b01, pulse `start`, `out_ready`=1.
  - Required: 50, 42, 51, 43, 56 on 5 consecutive cycles.
  - `out_last` only with 56; `busy` drops on the next edge.
- Same stimulus with `out_ready` toggled 1,0,0,1,0,1…
  - Required: each character is held stable while `out_ready`=0.
  - Stream and order are identical to the previous test; exactly 5 transfers.
- `num_terms`=1, digit 7.
  - Required: a single 55 with `out_valid`=`out_last`=1; next cycle IDLE.
- `num_terms`=2, digits {0xA, 4}.
  - Required: `err`=1, `out_valid` never rises, `busy` stays 0.
  - A following valid start clears `err`.
- Assert `clr` after 2 transfers of a 3-term expression.
  - Required: next cycle all outputs are 0.
  - A new `start` with `num_terms`=2, digits {9,1}, op '+' yields 49, 43, 57.
- Pulse `start` with different data while `busy`=1.
  - Required: the in-flight stream is unchanged and no second expression follows.
